// File: rtl/shield_read_line_buf_if.sv
// Bundle of the accelerator AXI read channels, the read-master line fetch
// handshake and the write-path invalidate port of shield_read_line_buf.
interface shield_read_line_buf_if #(
    parameter int unsigned SHIELD_ADDR_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH      = 16,
    parameter int unsigned LINE_WIDTH        = 512
);
    logic [AXI_ID_WIDTH-1:0]      s_axi_arid;
    logic [SHIELD_ADDR_WIDTH-1:0] s_axi_araddr;
    logic [7:0]                   s_axi_arlen;
    logic                         s_axi_arvalid;
    logic                         s_axi_arready;

    logic [AXI_ID_WIDTH-1:0]      s_axi_rid;
    logic [LINE_WIDTH-1:0]        s_axi_rdata;
    logic [1:0]                   s_axi_rresp;
    logic                         s_axi_rlast;
    logic                         s_axi_rvalid;
    logic                         s_axi_rready;

    logic [SHIELD_ADDR_WIDTH-1:0] line_req_addr;
    logic                         line_req_val;
    logic                         line_req_rdy;

    logic [SHIELD_ADDR_WIDTH-1:0] line_resp_addr;
    logic [LINE_WIDTH-1:0]        line_resp_data;
    logic                         line_resp_val;
    logic                         line_resp_rdy;

    logic [SHIELD_ADDR_WIDTH-1:0] inv_addr;
    logic                         inv_val;
    logic                         busy;

    // Line buffer side
    modport slave (
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  s_axi_rready,
        output line_req_addr, line_req_val,
        input  line_req_rdy,
        input  line_resp_addr, line_resp_data, line_resp_val,
        output line_resp_rdy,
        input  inv_addr, inv_val,
        output busy
    );

    // Accelerator / read master / write path side
    modport master (
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output s_axi_rready,
        input  line_req_addr, line_req_val,
        output line_req_rdy,
        output line_resp_addr, line_resp_data, line_resp_val,
        input  line_resp_rdy,
        output inv_addr, inv_val,
        input  busy
    );
endinterface

// File: rtl/shield_read_line_buf.sv
// Single-line read buffer between an AXI read accelerator port and the
// decrypting read master. Line reuse on hit is enabled by SHIELD_LINE_REUSE_EN.
module shield_read_line_buf #(
    parameter int unsigned SHIELD_ADDR_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH      = 16,
    parameter int unsigned LINE_WIDTH        = 512,
    parameter int unsigned OFFSET_WIDTH      = 6
) (
    input logic                  clk,
    input logic                  rst_n,
    shield_read_line_buf_if.slave bus
);
    localparam int unsigned AW         = SHIELD_ADDR_WIDTH;
    localparam int unsigned IW         = AXI_ID_WIDTH;
    localparam int unsigned LW         = LINE_WIDTH;
    localparam int unsigned OW         = OFFSET_WIDTH;
    localparam int unsigned LINE_BYTES = 32'd1 << OW;
    localparam logic [AW-1:0] LINE_MASK = {{(AW-OW){1'b1}}, {OW{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FETCH_REQ,
        ST_FETCH_WAIT,
        ST_SEND
    } state_t;

    state_t state_q, state_nxt;

    logic [IW-1:0] id_q;
    logic [7:0]    len_q;
    logic [AW-1:0] beat_addr_q;
    logic [7:0]    beat_cnt_q;
    logic [AW-1:0] tag_q;
    logic [LW-1:0] data_q;
    logic          valid_q;

    logic arready_q, rvalid_q, rlast_q, line_req_val_q, line_resp_rdy_q, busy_q;
    logic arready_d, rvalid_d, rlast_d, line_req_val_d, line_resp_rdy_d, busy_d;

    logic [AW-1:0] inv_line;
    logic          inv_tag;
    logic          inv_beat;
    logic          ar_hs;
    logic          r_hs;
    logic          fill;
    logic          adv;
    logic          hit;
    logic          unused_resp_addr;

    // Handshakes and invalidate matches
    assign inv_line = bus.inv_addr & LINE_MASK;
    assign inv_tag  = bus.inv_val && (inv_line == tag_q);
    assign inv_beat = bus.inv_val && (inv_line == beat_addr_q);
    assign ar_hs    = bus.s_axi_arvalid && arready_q;
    assign r_hs     = rvalid_q && bus.s_axi_rready;
    assign fill     = (state_q == ST_FETCH_WAIT) && bus.line_resp_val;
    assign adv      = (state_q == ST_SEND) && r_hs && !rlast_q;

    // A same-cycle invalidate of the buffered line forces a miss
`ifdef SHIELD_LINE_REUSE_EN
    assign hit = valid_q && (tag_q == beat_addr_q) && !inv_tag;
`else
    assign hit = 1'b0;
`endif

    assign unused_resp_addr = ^bus.line_resp_addr;

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            ST_IDLE:       if (ar_hs) state_nxt = ST_LOOKUP;
            ST_LOOKUP:     state_nxt = hit ? ST_SEND : ST_FETCH_REQ;
            ST_FETCH_REQ:  if (bus.line_req_rdy) state_nxt = ST_FETCH_WAIT;
            ST_FETCH_WAIT: if (bus.line_resp_val) state_nxt = ST_SEND;
            ST_SEND:       if (r_hs) state_nxt = rlast_q ? ST_IDLE : ST_LOOKUP;
            default:       state_nxt = ST_IDLE;
        endcase

        // rvalid rises one cycle into SEND, giving a two-edge hit latency
        arready_d       = (state_nxt == ST_IDLE);
        line_req_val_d  = (state_nxt == ST_FETCH_REQ);
        line_resp_rdy_d = (state_nxt == ST_FETCH_WAIT);
        busy_d          = (state_nxt != ST_IDLE);
        rvalid_d        = (state_q == ST_SEND) && !r_hs;
        rlast_d         = rvalid_d && (beat_cnt_q == len_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            arready_q       <= 1'b1;
            rvalid_q        <= 1'b0;
            rlast_q         <= 1'b0;
            line_req_val_q  <= 1'b0;
            line_resp_rdy_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_nxt;
            arready_q       <= arready_d;
            rvalid_q        <= rvalid_d;
            rlast_q         <= rlast_d;
            line_req_val_q  <= line_req_val_d;
            line_resp_rdy_q <= line_resp_rdy_d;
            busy_q          <= busy_d;
        end
    end

    // Burst tracking and the line buffer itself
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_q        <= '0;
            len_q       <= '0;
            beat_addr_q <= '0;
            beat_cnt_q  <= '0;
            tag_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            if (ar_hs) begin
                id_q        <= bus.s_axi_arid;
                len_q       <= bus.s_axi_arlen;
                beat_addr_q <= bus.s_axi_araddr & LINE_MASK;
                beat_cnt_q  <= 8'd0;
            end else if (adv) begin
                beat_addr_q <= beat_addr_q + AW'(LINE_BYTES);
                beat_cnt_q  <= beat_cnt_q + 8'd1;
            end

            // A fill racing an invalidate of the same line still serves the beat
            if (fill) begin
                data_q  <= bus.line_resp_data;
                tag_q   <= beat_addr_q;
                valid_q <= !inv_beat;
            end else if (valid_q && inv_tag) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.s_axi_arready = arready_q;
    assign bus.s_axi_rid     = id_q;
    assign bus.s_axi_rdata   = data_q;
    assign bus.s_axi_rresp   = 2'b00;
    assign bus.s_axi_rlast   = rlast_q;
    assign bus.s_axi_rvalid  = rvalid_q;
    assign bus.line_req_addr = beat_addr_q;
    assign bus.line_req_val  = line_req_val_q;
    assign bus.line_resp_rdy = line_resp_rdy_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_shield_read_line_buf.sv
// Directed bench for shield_read_line_buf: misses, reuse hits, multi-beat
// bursts with back-pressure, invalidation races and mid-burst reset.
module tb_shield_read_line_buf;
    localparam int unsigned AW = 32;
    localparam int unsigned IW = 16;
    localparam int unsigned LW = 512;
`ifdef SHIELD_LINE_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    shield_read_line_buf_if #(.SHIELD_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .LINE_WIDTH(LW)) bus ();

    shield_read_line_buf #(
        .SHIELD_ADDR_WIDTH(AW),
        .AXI_ID_WIDTH     (IW),
        .LINE_WIDTH       (LW),
        .OFFSET_WIDTH     (6)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] line_pat(input logic [AW-1:0] a);
        return {16{a ^ 32'hC3C3_0000}};
    endfunction

    // One AR burst; the read master answers every fetch one cycle after accepting it
    task automatic read_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                              input logic [IW-1:0] id, input bit exp_fetch,
                              input bit stall, input bit inv_fill);
        logic [AW-1:0] beat;
        int            cyc;
        bit            saw_fetch;
        beat = addr & 32'hFFFF_FFC0;
        @(negedge clk);
        bus.s_axi_arid    = id;
        bus.s_axi_araddr  = addr;
        bus.s_axi_arlen   = len;
        bus.s_axi_arvalid = 1'b1;
        check("arready_before_ar", LW'(bus.s_axi_arready), LW'(1'b1));
        @(negedge clk);
        bus.s_axi_arvalid = 1'b0;
        check("busy_in_burst", LW'(bus.busy), LW'(1'b1));
        for (int i = 0; i <= int'(len); i++) begin
            cyc       = 0;
            saw_fetch = 1'b0;
            while (!bus.s_axi_rvalid && cyc < 40) begin
                if (bus.line_req_val) begin
                    saw_fetch = 1'b1;
                    check("line_req_addr", LW'(bus.line_req_addr), LW'(beat));
                    @(negedge clk);
                    cyc++;
                    check("line_resp_rdy", LW'(bus.line_resp_rdy), LW'(1'b1));
                    bus.line_resp_val  = 1'b1;
                    bus.line_resp_data = line_pat(beat);
                    bus.line_resp_addr = beat;
                    if (inv_fill) begin
                        bus.inv_val  = 1'b1;
                        bus.inv_addr = beat;
                    end
                    @(negedge clk);
                    cyc++;
                    bus.line_resp_val = 1'b0;
                    bus.inv_val       = 1'b0;
                end else begin
                    @(negedge clk);
                    cyc++;
                end
            end
            check("fetch_issued", LW'(saw_fetch), LW'(exp_fetch));
            if (!exp_fetch) check("hit_latency", LW'(cyc), LW'(2));
            check("rvalid", LW'(bus.s_axi_rvalid), LW'(1'b1));
            check("rdata", bus.s_axi_rdata, line_pat(beat));
            check("rid", LW'(bus.s_axi_rid), LW'(id));
            check("rresp", LW'(bus.s_axi_rresp), LW'(2'b00));
            check("rlast", LW'(bus.s_axi_rlast), LW'(i == int'(len)));
            if (stall && (i % 2 == 0)) begin
                repeat (2) @(negedge clk);
                check("stall_rvalid", LW'(bus.s_axi_rvalid), LW'(1'b1));
                check("stall_rdata", bus.s_axi_rdata, line_pat(beat));
                check("stall_rlast", LW'(bus.s_axi_rlast), LW'(i == int'(len)));
            end
            bus.s_axi_rready = 1'b1;
            @(negedge clk);
            bus.s_axi_rready = 1'b0;
            check("rvalid_drop", LW'(bus.s_axi_rvalid), LW'(1'b0));
            beat = beat + 32'h40;
        end
        check("busy_after_burst", LW'(bus.busy), LW'(1'b0));
        check("arready_after_burst", LW'(bus.s_axi_arready), LW'(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.s_axi_arid     = '0;
        bus.s_axi_araddr   = '0;
        bus.s_axi_arlen    = '0;
        bus.s_axi_arvalid  = 1'b0;
        bus.s_axi_rready   = 1'b0;
        bus.line_req_rdy   = 1'b1;
        bus.line_resp_addr = '0;
        bus.line_resp_data = '0;
        bus.line_resp_val  = 1'b0;
        bus.inv_addr       = '0;
        bus.inv_val        = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_arready", LW'(bus.s_axi_arready), LW'(1'b1));
        check("rst_rvalid", LW'(bus.s_axi_rvalid), LW'(1'b0));
        check("rst_rlast", LW'(bus.s_axi_rlast), LW'(1'b0));
        check("rst_line_req_val", LW'(bus.line_req_val), LW'(1'b0));
        check("rst_line_resp_rdy", LW'(bus.line_resp_rdy), LW'(1'b0));
        check("rst_busy", LW'(bus.busy), LW'(1'b0));
        rst_n = 1'b1;

        // Cold miss, then the same line again
        read_burst(32'h0000_1040, 8'd0, 16'h1234, 1'b1, 1'b0, 1'b0);
        read_burst(32'h0000_1040, 8'd0, 16'h0055, !REUSE, 1'b0, 1'b0);

        // Four-beat burst with back-pressure, then its last line again
        read_burst(32'h0000_2000, 8'd3, 16'hBEEF, 1'b1, 1'b1, 1'b0);
        read_burst(32'h0000_20C0, 8'd0, 16'h0007, !REUSE, 1'b0, 1'b0);

        // Invalidate by an unaligned address inside the buffered line
        read_burst(32'h0000_3000, 8'd0, 16'h0301, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        bus.inv_val  = 1'b1;
        bus.inv_addr = 32'h0000_3010;
        @(negedge clk);
        bus.inv_val  = 1'b0;
        read_burst(32'h0000_3000, 8'd0, 16'h0302, 1'b1, 1'b0, 1'b0);

        // Invalidate on the fill edge
        read_burst(32'h0000_4000, 8'd0, 16'h0401, 1'b1, 1'b0, 1'b1);
        read_burst(32'h0000_4000, 8'd0, 16'h0402, 1'b1, 1'b0, 1'b0);

        // Reset while waiting for a line; the earlier line must not survive it
        read_burst(32'h0000_6000, 8'd0, 16'h0601, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        bus.s_axi_arid    = 16'h0701;
        bus.s_axi_araddr  = 32'h0000_7000;
        bus.s_axi_arlen   = 8'd2;
        bus.s_axi_arvalid = 1'b1;
        @(negedge clk);
        bus.s_axi_arvalid = 1'b0;
        cyc = 0;
        while (!bus.line_resp_rdy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_fetch_wait", LW'(bus.line_resp_rdy), LW'(1'b1));
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_rvalid", LW'(bus.s_axi_rvalid), LW'(1'b0));
        rst_n = 1'b1;
        check("post_rst_arready", LW'(bus.s_axi_arready), LW'(1'b1));
        check("post_rst_busy", LW'(bus.busy), LW'(1'b0));
        check("post_rst_line_resp_rdy", LW'(bus.line_resp_rdy), LW'(1'b0));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_no_beat", LW'(bus.s_axi_rvalid), LW'(1'b0));
        end
        read_burst(32'h0000_6000, 8'd0, 16'h0602, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/shield_read_line_buf.md
SHIELD_READ_LINE_BUF -- requirements
Module: shield_read_line_buf

Interface
REQ-001 SHALL have parameter SHIELD_ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter AXI_ID_WIDTH, default 16, accelerator read ID width.
REQ-003 SHALL have parameter LINE_WIDTH, default 512, line/beat data width.
REQ-004 SHALL have parameter OFFSET_WIDTH, default 6, log2 of line bytes.
REQ-005 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports: s_axi_arid  in  AXI_ID_WIDTH; s_axi_araddr  in  SHIELD_ADDR_WIDTH; s_axi_arlen  in  8; s_axi_arvalid  in  1; s_axi_arready  out  1 (accelerator read address).
REQ-007 SHALL have ports: s_axi_rid  out  AXI_ID_WIDTH; s_axi_rdata  out  LINE_WIDTH; s_axi_rresp  out  2; s_axi_rlast  out  1; s_axi_rvalid  out  1; s_axi_rready  in  1 (accelerator read data).
REQ-008 SHALL have ports: line_req_addr  out  SHIELD_ADDR_WIDTH; line_req_val  out  1; line_req_rdy  in  1 (line fetch request to the read master).
REQ-009 SHALL have ports: line_resp_addr  in  SHIELD_ADDR_WIDTH (ignored); line_resp_data  in  LINE_WIDTH; line_resp_val  in  1; line_resp_rdy  out  1 (decrypted line from the read master).
REQ-010 SHALL have ports: inv_addr  in  SHIELD_ADDR_WIDTH; inv_val  in  1 (write-path invalidate); busy  out  1.

Function
REQ-011 SHALL hold one line buffer: data register, tag (line address), valid bit.
REQ-012 SHALL use FSM states IDLE, LOOKUP, FETCH_REQ, FETCH_WAIT, SEND; one AR burst outstanding at most.
REQ-013 IDLE: arready=1; on arvalid&&arready capture arid, arlen, beat address = araddr with low OFFSET_WIDTH bits cleared, beat count=0; go LOOKUP.
REQ-014 LOOKUP: hit (valid && tag==beat address) -> SEND; miss -> FETCH_REQ.
REQ-015 FETCH_REQ: line_req_val=1, line_req_addr=beat address; on line_req_rdy -> FETCH_WAIT.
REQ-016 FETCH_WAIT: line_resp_rdy=1; on line_resp_val load data register, tag=beat address, valid=1; -> SEND.
REQ-017 SEND: rvalid=1, rdata=data register, rid=captured ID, rresp=2'b00, rlast=(beat count==arlen); all held stable while rvalid&&!rready.
REQ-018 On R handshake: if rlast -> IDLE; else beat address += 2^OFFSET_WIDTH (wraps modulo 2^SHIELD_ADDR_WIDTH), beat count += 1, -> LOOKUP.
REQ-019 Hit latency: AR handshake at edge N, rvalid asserted after edge N+2; miss adds FETCH_REQ/FETCH_WAIT cycles.
REQ-020 inv_val with valid && tag==inv_addr line-aligned SHALL clear valid at next edge, in any state.
REQ-021 inv_val matching the line being filled on the same edge as the fill: data delivered to current beat, valid left 0.
REQ-022 inv_val in LOOKUP matching tag SHALL force a miss in that cycle.
REQ-023 busy=1 whenever state != IDLE.
REQ-024 arsize/arburst not ported; every beat is one full line, INCR.

Reset
REQ-025 While rst_n low at an edge: state=IDLE, valid=0, beat count=0.
REQ-026 Output values after reset: arready=1, rvalid=0, rlast=0, line_req_val=0, line_resp_rdy=0, busy=0.
REQ-027 Reset mid-burst SHALL abandon the burst with no further R beats; read master shares rst_n.

Configuration
REQ-028 Macro SHIELD_LINE_REUSE_EN: when defined, hit path per REQ-014 enabled.
REQ-029 When SHIELD_LINE_REUSE_EN undefined, LOOKUP SHALL always go FETCH_REQ (every beat refetched); valid still maintained but never used.

Verification
REQ-030 araddr=0x1040, arlen=0, empty buffer -> line_req_addr=0x1040, returned line data on rdata, rlast=1, rid echoed.
REQ-031 Repeat araddr=0x1040 with REUSE_EN -> no line_req_val, rvalid two cycles after AR handshake; without macro -> new fetch.
REQ-032 araddr=0x2000, arlen=3, rready toggling -> line fetches 0x2000/0x2040/0x2080/0x20C0 in order, rlast only on 4th beat, rdata stable while stalled.
REQ-033 Buffer holds 0x3000; inv_val inv_addr=0x3010; read 0x3000 -> refetch issued.
REQ-034 inv_val for 0x4000 on fill edge of 0x4000 -> beat returns data, next read of 0x4000 refetches.
REQ-035 rst_n low during FETCH_WAIT -> rvalid stays 0, arready=1 after reset, next read misses.
